// File: rtl/debounce_multi.sv
// Multi-channel input debouncer: per-channel synchroniser, stability counter FSM,
// registered clean level and single-cycle rise/fall pulses.
module debounce_multi #(
  parameter int unsigned NUM_CHANNELS           = 4,
  parameter int unsigned DEBOUNCE_COUNTER_WIDTH = 24,
  parameter int unsigned SYNC_STAGES            = 2,
  parameter bit          RESET_LEVEL            = 1'b0
) (
  input  logic                              i_clock,
  input  logic                              i_reset,
  input  logic [DEBOUNCE_COUNTER_WIDTH-1:0] i_debounce_counter,
  input  logic [NUM_CHANNELS-1:0]           i_bouncing_signal,
  output logic [NUM_CHANNELS-1:0]           o_debounced_signal,
  output logic [NUM_CHANNELS-1:0]           o_rise_pulse,
  output logic [NUM_CHANNELS-1:0]           o_fall_pulse,
  output logic [NUM_CHANNELS-1:0]           o_busy
);

  localparam int unsigned W = DEBOUNCE_COUNTER_WIDTH;
  localparam logic [W-1:0] CNT_ONE = W'(1);

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_FILTER = 1'b1
  } state_e;

  // A zero request still needs one edge of agreement before the output moves.
  logic [W-1:0] d_eff;
  assign d_eff = (i_debounce_counter == '0) ? CNT_ONE : i_debounce_counter;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_e                 state_q, state_d;
    logic [W-1:0]           count_q, count_d;
    logic [W-1:0]           deff_q, deff_d;
    logic                   out_q, out_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge i_clock) begin
      if (i_reset) begin
        sync_q <= {SYNC_STAGES{RESET_LEVEL}};
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], i_bouncing_signal[c]};
      end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge i_clock) begin
      if (i_reset) begin
        state_q <= ST_STABLE;
        count_q <= '0;
        deff_q  <= '0;
        out_q   <= RESET_LEVEL;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        count_q <= count_d;
        deff_q  <= deff_d;
        out_q   <= out_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
      end
    end

    // NOTE: every next-state signal gets a default first so no latch is inferred.
    always_comb begin
      state_d = state_q;
      count_d = count_q;
      deff_d  = deff_q;
      out_d   = out_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      unique case (state_q)
        ST_STABLE: begin
          if (s != out_q) begin
            deff_d = d_eff;
            if (d_eff == CNT_ONE) begin
              out_d   = s;
              rise_d  = s;
              fall_d  = ~s;
              count_d = '0;
            end else begin
              count_d = CNT_ONE;
              state_d = ST_FILTER;
            end
          end
        end
        ST_FILTER: begin
          if (s == out_q) begin
            count_d = '0;
            state_d = ST_STABLE;
          end else if (count_q + CNT_ONE == deff_q) begin
            // count_q stays below deff_q, so the increment cannot wrap.
            out_d   = s;
            rise_d  = s;
            fall_d  = ~s;
            count_d = '0;
            state_d = ST_STABLE;
          end else begin
            count_d = count_q + CNT_ONE;
          end
        end
        default: state_d = ST_STABLE;
      endcase
    end

    assign o_debounced_signal[c] = out_q;
    assign o_rise_pulse[c]       = rise_q;
    assign o_fall_pulse[c]       = fall_q;
    assign o_busy[c]             = (state_q == ST_FILTER);
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: run-length reference model checked every cycle,
// plus directed latency/pulse-count checks for each scenario.
module tb_debounce_multi;

  localparam int NC = 4;
  localparam int W  = 24;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  dcnt = W'(10);
  logic [NC-1:0] pin = '0;
  logic [NC-1:0] dut_out, dut_rise, dut_fall, dut_busy;

  debounce_multi #(
    .NUM_CHANNELS(NC), .DEBOUNCE_COUNTER_WIDTH(W), .SYNC_STAGES(SS), .RESET_LEVEL(1'b0)
  ) dut (
    .i_clock(clk),
    .i_reset(rst),
    .i_debounce_counter(dcnt),
    .i_bouncing_signal(pin),
    .o_debounced_signal(dut_out),
    .o_rise_pulse(dut_rise),
    .o_fall_pulse(dut_fall),
    .o_busy(dut_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Reference model: the pin delayed by SS edges must disagree with the output
  // for D_eff consecutive edges; D_eff is fixed when a disagreement run starts.
  logic [NC-1:0] m_out = '0, m_rise = '0, m_fall = '0, m_busy = '0;
  int  run [NC];
  int  m_deff [NC];
  bit  hist [NC][SS];

  always @(posedge clk) begin : model_p
    bit s;
    edge_cnt++;
    for (int c = 0; c < NC; c++) begin
      if (rst) begin
        for (int k = 0; k < SS; k++) hist[c][k] = 1'b0;
        m_out[c] = 1'b0; m_rise[c] = 1'b0; m_fall[c] = 1'b0; run[c] = 0;
      end else begin
        s = hist[c][SS-1];
        m_rise[c] = 1'b0;
        m_fall[c] = 1'b0;
        if (s == m_out[c]) begin
          run[c] = 0;
        end else begin
          if (run[c] == 0) m_deff[c] = (dcnt == 0) ? 1 : int'(dcnt);
          run[c]++;
          if (run[c] == m_deff[c]) begin
            m_out[c]  = s;
            m_rise[c] = s;
            m_fall[c] = !s;
            run[c]    = 0;
          end
        end
        for (int k = SS - 1; k > 0; k--) hist[c][k] = hist[c][k-1];
        hist[c][0] = pin[c];
      end
      m_busy[c] = (run[c] != 0);
    end
  end

  int rise_cnt [NC], fall_cnt [NC], busy_cnt [NC], last_rise [NC], last_fall [NC];

  always @(negedge clk) begin
    if (check_en) begin
      check("debounced", 32'(dut_out), 32'(m_out));
      check("rise_pulse", 32'(dut_rise), 32'(m_rise));
      check("fall_pulse", 32'(dut_fall), 32'(m_fall));
      check("busy", 32'(dut_busy), 32'(m_busy));
      check("rise_and_fall", 32'(|(dut_rise & dut_fall)), 32'd0);
      for (int c = 0; c < NC; c++) begin
        if (dut_rise[c] === 1'b1) begin rise_cnt[c]++; last_rise[c] = edge_cnt; end
        if (dut_fall[c] === 1'b1) begin fall_cnt[c]++; last_fall[c] = edge_cnt; end
        if (dut_busy[c] === 1'b1) busy_cnt[c]++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    for (int c = 0; c < NC; c++) begin
      rise_cnt[c] = 0; fall_cnt[c] = 0; busy_cnt[c] = 0; last_rise[c] = -1; last_fall[c] = -1;
    end
  endtask

  initial begin : stim
    int e, e2;
    clear_stats();
    rst = 1'b1;
    tick(1);
    check_en = 1'b1;
    tick(1);
    check("reset_out", 32'(dut_out), 32'd0);
    check("reset_busy", 32'(dut_busy), 32'd0);
    check("reset_pulses", 32'(dut_rise | dut_fall), 32'd0);
    rst = 1'b0;
    tick(3);

    // 1: bursts on ch0, then steady high
    clear_stats();
    pin[0] = 1; tick(3); pin[0] = 0; tick(3);
    pin[0] = 1; tick(1); pin[0] = 0; tick(3);
    pin[0] = 1; tick(2); pin[0] = 0; tick(3);
    pin[0] = 1; tick(1); pin[0] = 0; tick(3);
    check("t1_no_rise_in_bursts", 32'(rise_cnt[0]), 32'd0);
    check("t1_out_low_after_bursts", 32'(dut_out[0]), 32'd0);
    pin[0] = 1; e = edge_cnt;
    tick(20);
    check("t1_rise_edge", 32'(last_rise[0]), 32'(e + 12));
    check("t1_rise_count", 32'(rise_cnt[0]), 32'd1);
    check("t1_out_high", 32'(dut_out[0]), 32'd1);
    pin[0] = 0; tick(15);

    // 2: 9-cycle pulse is rejected, busy for 9 cycles
    clear_stats();
    pin[0] = 1; tick(9); pin[0] = 0; tick(15);
    check("t2_busy_cycles", 32'(busy_cnt[0]), 32'd9);
    check("t2_no_rise", 32'(rise_cnt[0]), 32'd0);
    check("t2_out_low", 32'(dut_out[0]), 32'd0);

    // 3: staggered channels, rising then falling
    clear_stats();
    pin[1] = 1; e = edge_cnt; tick(5); pin[2] = 1; tick(20);
    check("t3_ch1_rise_edge", 32'(last_rise[1]), 32'(e + 12));
    check("t3_ch2_rise_edge", 32'(last_rise[2]), 32'(e + 17));
    check("t3_ch1_rise_count", 32'(rise_cnt[1]), 32'd1);
    check("t3_ch2_rise_count", 32'(rise_cnt[2]), 32'd1);
    check("t3_ch3_untouched", 32'(rise_cnt[3] + busy_cnt[3]), 32'd0);
    check("t3_out_vec", 32'(dut_out), 32'h6);
    pin[1] = 0; e = edge_cnt; tick(5); pin[2] = 0; tick(20);
    check("t3_ch1_fall_edge", 32'(last_fall[1]), 32'(e + 12));
    check("t3_ch2_fall_edge", 32'(last_fall[2]), 32'(e + 17));
    check("t3_fall_counts", 32'(fall_cnt[1] + fall_cnt[2]), 32'd2);
    check("t3_out_vec_low", 32'(dut_out), 32'h0);

    // 4: D=0 and D=1 behave as a 1-edge filter with no FILTER state
    for (int d = 0; d < 2; d++) begin
      dcnt = W'(d);
      clear_stats();
      pin[0] = 1; e = edge_cnt; tick(6);
      check("t4_rise_edge", 32'(last_rise[0]), 32'(e + 3));
      pin[0] = 0; e = edge_cnt; tick(6);
      check("t4_fall_edge", 32'(last_fall[0]), 32'(e + 3));
      check("t4_never_busy", 32'(busy_cnt[0]), 32'd0);
    end
    dcnt = W'(10);
    tick(2);

    // 5: reset while ch0 filter is at count 6
    clear_stats();
    pin[0] = 1; tick(8);
    rst = 1'b1; tick(1);
    check("t5_reset_out", 32'(dut_out), 32'd0);
    check("t5_reset_busy", 32'(dut_busy), 32'd0);
    check("t5_reset_pulses", 32'(dut_rise | dut_fall), 32'd0);
    rst = 1'b0; e2 = edge_cnt;
    tick(20);
    check("t5_rise_after_release", 32'(last_rise[0]), 32'(e2 + 12));
    check("t5_rise_count", 32'(rise_cnt[0]), 32'd1);
    pin[0] = 0; tick(15);

    // 6: D changes 10->3 while a filter is at count 2
    clear_stats();
    pin[0] = 1; e = edge_cnt; tick(4);
    dcnt = W'(3);
    tick(15);
    check("t6_old_d_rise_edge", 32'(last_rise[0]), 32'(e + 12));
    pin[0] = 0; e = edge_cnt; tick(10);
    check("t6_new_d_fall_edge", 32'(last_fall[0]), 32'(e + 5));

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
